// File: rtl/if_fetch_ctrl.sv
// ============================================================================
//  Module   : if_fetch_ctrl
//  Brief    : Instruction-fetch sequencer between PC stage and imem bus.
//             Optional bus timeout enabled with macro IF_TIMEOUT_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module if_fetch_ctrl #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_ce_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [5:0]        stall_i,
   input  logic              flush_i,
   output logic [DATA_W-1:0] inst_o,
   output logic              stallreq_o,
   output logic              bus_req_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   input  logic              bus_ack_i,
   input  logic [DATA_W-1:0] bus_rdata_i,
   output logic              bus_err_o
);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_BUSY       = 2'd1,
      S_WAIT_STALL = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_rd_buf;
   logic              w_issue;
   logic              w_capture;
   logic              w_timeout;

`ifdef IF_TIMEOUT_EN
   localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [TMO_W-1:0] r_tmo_cnt;

   // Timeout only fires when neither flush nor ack claim the cycle.
   assign w_timeout = (r_state == S_BUSY) && !flush_i && !bus_ack_i &&
                      (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
   assign bus_err_o = w_timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmo_cnt <= '0;
      end else if (w_issue) begin
         r_tmo_cnt <= '0;
      end else if (r_state == S_BUSY && !bus_ack_i) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end
`else
   logic unused_tmo;

   assign unused_tmo = (TIMEOUT_CYCLES == 0);
   assign w_timeout  = 1'b0;
   assign bus_err_o  = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      inst_o      = '0;
      stallreq_o  = 1'b0;
      w_issue     = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            stallreq_o = cpu_ce_i & ~flush_i;
            if (cpu_ce_i && !flush_i) begin
               w_issue     = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (flush_i) begin
               w_state_nxt = S_IDLE;
            end else if (bus_ack_i) begin
               // Forward the word in the ack cycle; buffer it only if stalled.
               inst_o      = bus_rdata_i;
               w_capture   = 1'b1;
               w_state_nxt = (stall_i != 6'd0) ? S_WAIT_STALL : S_IDLE;
            end else if (w_timeout) begin
               w_state_nxt = S_IDLE;
            end else begin
               stallreq_o = 1'b1;
            end
         end
         S_WAIT_STALL: begin
            inst_o = r_rd_buf;
            if (flush_i || !stall_i[0]) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         bus_req_o  <= 1'b0;
         bus_addr_o <= '0;
         r_rd_buf   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         // Request is high exactly while the FSM sits in BUSY.
         bus_req_o <= (w_state_nxt == S_BUSY);
         if (w_issue) begin
            bus_addr_o <= cpu_addr_i;
         end
         if (w_capture) begin
            r_rd_buf <= bus_rdata_i;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
// ============================================================================
//  Module   : tb_if_fetch_ctrl
//  Brief    : Directed self-checking bench for if_fetch_ctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        cpu_ce_i;
   logic [31:0] cpu_addr_i;
   logic [5:0]  stall_i;
   logic        flush_i;
   logic [31:0] inst_o;
   logic        stallreq_o;
   logic        bus_req_o;
   logic [31:0] bus_addr_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;
   logic        bus_err_o;

   int n_cmp;
   int n_fail;

   if_fetch_ctrl #(
      .ADDR_W        (32),
      .DATA_W        (32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_ce_i   (cpu_ce_i),
      .cpu_addr_i (cpu_addr_i),
      .stall_i    (stall_i),
      .flush_i    (flush_i),
      .inst_o     (inst_o),
      .stallreq_o (stallreq_o),
      .bus_req_o  (bus_req_o),
      .bus_addr_o (bus_addr_o),
      .bus_ack_i  (bus_ack_i),
      .bus_rdata_i(bus_rdata_i),
      .bus_err_o  (bus_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge, then leave 1 time unit for registered outputs.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp       = 0;
      n_fail      = 0;
      rst         = 1'b1;
      cpu_ce_i    = 1'b0;
      cpu_addr_i  = '0;
      stall_i     = '0;
      flush_i     = 1'b0;
      bus_ack_i   = 1'b0;
      bus_rdata_i = '0;
      step();
      step();
      #1;
      chk1 ("rst_req",      bus_req_o,  1'b0);
      chk32("rst_addr",     bus_addr_o, 32'h0);
      chk32("rst_inst",     inst_o,     32'h0);
      chk1 ("rst_stallreq", stallreq_o, 1'b0);
      chk1 ("rst_err",      bus_err_o,  1'b0);

      // Basic fetch, ack one cycle after request
      rst = 1'b0; cpu_ce_i = 1'b1; cpu_addr_i = 32'h10;
      #1;
      chk1("t1_issue_stallreq", stallreq_o, 1'b1);
      chk1("t1_issue_req",      bus_req_o,  1'b0);
      step();
      chk1 ("t1_busy_req",  bus_req_o,  1'b1);
      chk32("t1_busy_addr", bus_addr_o, 32'h10);
      bus_ack_i = 1'b1; bus_rdata_i = 32'h2408_0005;
      #1;
      chk32("t1_ack_inst",     inst_o,     32'h2408_0005);
      chk1 ("t1_ack_stallreq", stallreq_o, 1'b0);
      step();
      bus_ack_i = 1'b0; cpu_ce_i = 1'b1; cpu_addr_i = 32'h20;
      #1;
      chk1 ("t1_idle_req",      bus_req_o,  1'b0);
      chk32("t1_idle_inst",     inst_o,     32'h0);
      chk1 ("t1_idle_stallreq", stallreq_o, 1'b1);

      // Ack under stall: word must be held from the buffer
      step();
      chk32("t2_busy_addr", bus_addr_o, 32'h20);
      bus_ack_i = 1'b1; bus_rdata_i = 32'h3C01_ABCD; stall_i = 6'b000011;
      #1;
      chk32("t2_ack_inst", inst_o, 32'h3C01_ABCD);
      step();
      bus_ack_i = 1'b0; bus_rdata_i = 32'hDEAD_BEEF;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk32("t2_hold_inst",     inst_o,     32'h3C01_ABCD);
         chk1 ("t2_hold_stallreq", stallreq_o, 1'b0);
         chk1 ("t2_hold_req",      bus_req_o,  1'b0);
         if (i < 2) step();
      end
      step();
      stall_i = 6'b000000;
      #1;
      chk32("t2_release_inst", inst_o,    32'h3C01_ABCD);
      chk1 ("t2_release_req",  bus_req_o, 1'b0);
      step();
      chk1("t2_idle_req",      bus_req_o,  1'b0);
      chk1("t2_idle_stallreq", stallreq_o, 1'b1);
      step();
      chk1 ("t2_reissue_req",  bus_req_o,  1'b1);
      chk32("t2_reissue_addr", bus_addr_o, 32'h20);

      // Flush coincident with ack: data dropped, no WAIT_STALL
      bus_ack_i = 1'b1; flush_i = 1'b1; bus_rdata_i = 32'h1111_1111; stall_i = 6'b000011;
      #1;
      chk32("t3_flush_inst",     inst_o,     32'h0);
      chk1 ("t3_flush_stallreq", stallreq_o, 1'b0);
      step();
      bus_ack_i = 1'b0; flush_i = 1'b0; stall_i = 6'b000000; cpu_addr_i = 32'h180;
      #1;
      chk1 ("t3_idle_req",      bus_req_o,  1'b0);
      chk32("t3_idle_inst",     inst_o,     32'h0);
      chk1 ("t3_idle_stallreq", stallreq_o, 1'b1);
      step();
      chk1 ("t3_new_req",  bus_req_o,  1'b1);
      chk32("t3_new_addr", bus_addr_o, 32'h180);

      // Delayed ack; PC change during BUSY must not move the bus address
      cpu_addr_i = 32'h44;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk1 ("t5_wait_stallreq", stallreq_o, 1'b1);
         chk32("t5_wait_addr",     bus_addr_o, 32'h180);
         chk1 ("t5_wait_req",      bus_req_o,  1'b1);
         chk1 ("t5_wait_err",      bus_err_o,  1'b0);
         step();
      end
      bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_0001;
      #1;
      chk1 ("t5_ack_stallreq", stallreq_o, 1'b0);
      chk32("t5_ack_inst",     inst_o,     32'hCAFE_0001);
      chk1 ("t5_ack_err",      bus_err_o,  1'b0);
      step();
      bus_ack_i = 1'b0; cpu_addr_i = 32'h200;
      #1;
      chk1("t5_done_req", bus_req_o, 1'b0);

      // Reset while a request is pending
      step();
      chk1 ("t4_busy_req",  bus_req_o,  1'b1);
      chk32("t4_busy_addr", bus_addr_o, 32'h200);
      rst = 1'b1;
      step();
      rst = 1'b0; cpu_ce_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_5555;
      #1;
      chk1 ("t4_rst_req",      bus_req_o,  1'b0);
      chk32("t4_rst_addr",     bus_addr_o, 32'h0);
      chk32("t4_late_inst",    inst_o,     32'h0);
      chk1 ("t4_late_stallreq", stallreq_o, 1'b0);
      step();
      bus_ack_i = 1'b0;
      #1;
      chk1 ("t4_after_req",  bus_req_o, 1'b0);
      chk32("t4_after_inst", inst_o,    32'h0);

      // Timeout behaviour (or its absence)
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h300;
      step();
      cpu_ce_i = 1'b0;
      #1;
`ifdef IF_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         chk1("t6_wait_err",      bus_err_o,  1'b0);
         chk1("t6_wait_stallreq", stallreq_o, 1'b1);
         step();
      end
      chk1 ("t6_tmo_err",      bus_err_o,  1'b1);
      chk1 ("t6_tmo_stallreq", stallreq_o, 1'b0);
      chk32("t6_tmo_inst",     inst_o,     32'h0);
      chk1 ("t6_tmo_req",      bus_req_o,  1'b1);
      step();
      chk1("t6_post_req", bus_req_o, 1'b0);
      chk1("t6_post_err", bus_err_o, 1'b0);
`else
      for (int i = 0; i < 8; i++) begin
         chk1("t6_noto_err", bus_err_o, 1'b0);
         chk1("t6_noto_req", bus_req_o, 1'b1);
         step();
      end
      bus_ack_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D;
      #1;
      chk32("t6_noto_inst", inst_o, 32'h0BAD_F00D);
      step();
      bus_ack_i = 1'b0;
      #1;
      chk1("t6_noto_done", bus_req_o, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch sequencer between the PC stage and the instruction memory bus. It launches one word fetch per PC value, holds the pipeline (stall request) until the bus acknowledges, and buffers the fetched word while downstream stages are stalled. It also drops in-flight fetches on pipeline flush. The PC register's stall[0] is driven indirectly: this block's stallreq feeds the pipeline control unit, which produces the 6-bit stall vector.

Parameters:
ADDR_W, 32, address width of cpu_addr_i / bus_addr_o
DATA_W, 32, instruction word width
TIMEOUT_CYCLES, 255, bus wait limit in cycles; used only with IF_TIMEOUT_EN

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
cpu_ce_i  in  1  fetch enable from PC stage (PC chip-enable)
cpu_addr_i  in  ADDR_W  current PC value
stall_i  in  6  pipeline stall vector; bit0 = PC stage, bit1 = IF/ID
flush_i  in  1  pipeline flush; PC is being redirected
inst_o  out  DATA_W  instruction to IF/ID register
stallreq_o  out  1  stall request to pipeline control
bus_req_o  out  1  bus request, registered
bus_addr_o  out  ADDR_W  bus address, registered
bus_ack_i  in  1  one-cycle data-valid from memory
bus_rdata_i  in  DATA_W  read data, valid when bus_ack_i=1
bus_err_o  out  1  fetch timeout pulse (tied 0 without IF_TIMEOUT_EN)

Behaviour:
- Bus protocol: bus_req_o held high with bus_addr_o stable until bus_ack_i. Deasserting bus_req_o before ack aborts the access. Any ack seen outside BUSY is ignored.
- States: IDLE, BUSY, WAIT_STALL. Reset: state=IDLE, bus_req_o=0, bus_addr_o=0, rd_buf=0, timeout count=0. rst wins over every other input, including mid-BUSY; bus_req_o falls on that edge.
- IDLE:
  - cpu_ce_i=1 and flush_i=0: next edge bus_req_o<=1, bus_addr_o<=cpu_addr_i, go BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - flush_i=1 has priority: bus_req_o<=0, go IDLE, data discarded even if bus_ack_i=1 in the same cycle.
  - Else if bus_ack_i=1: bus_req_o<=0, rd_buf<=bus_rdata_i. If stall_i!=0, go WAIT_STALL; else go IDLE.
  - Else remain in BUSY.
- WAIT_STALL:
  - flush_i=1: go IDLE.
  - Else if stall_i[0]=0: go IDLE.
  - Else hold.
- Combinational outputs:
  - IDLE: stallreq_o = cpu_ce_i & ~flush_i; inst_o = 0.
  - BUSY with ack and no flush: stallreq_o = 0; inst_o = bus_rdata_i (zero-latency forward).
  - BUSY otherwise: stallreq_o = ~flush_i; inst_o = 0.
  - WAIT_STALL: stallreq_o = 0; inst_o = rd_buf.
- Latency: minimum 2 cycles per fetch (issue edge, then ack cycle). Throughput is 1 word per 2 cycles with single-cycle memory.
- cpu_addr_i is sampled only on the IDLE->BUSY edge. PC changes during BUSY have no effect until the next issue.
- inst_o = 0 is an architectural NOP.

Optional Feature:
IF_TIMEOUT_EN.
- With the macro: an 8-bit+ counter clears on entry to BUSY and increments each BUSY cycle without ack. On reaching TIMEOUT_CYCLES:
  - bus_req_o<=0 and go IDLE.
  - bus_err_o=1 for exactly that one cycle (combinational from count==TIMEOUT_CYCLES in BUSY).
  - stallreq_o=0 and inst_o=0 in that cycle.
  - Flush or ack in the same cycle take priority over timeout; no bus_err_o is raised.
- Without the macro: no counter; BUSY waits indefinitely; bus_err_o is constant 0.

Test Plan:
- Reset then cpu_ce_i=1, cpu_addr_i=0x0000_0010, ack 1 cycle after req with rdata=0x2408_0005 -> bus_addr_o=0x10; stallreq_o=1 in the issue cycle; inst_o=0x2408_0005 and stallreq_o=0 in the ack cycle; state returns to IDLE.
- Ack with stall_i=6'b000011 held 3 cycles, rdata=0x3C01_ABCD -> inst_o=0x3C01_ABCD for all 3 stall cycles; next fetch issued only after stall_i[0]=0.
- flush_i=1 in the same cycle as bus_ack_i=1 -> inst_o=0, bus_req_o=0 next edge, no WAIT_STALL; next fetch uses the new cpu_addr_i=0x0000_0180.
- rst=1 while BUSY with req pending -> bus_req_o=0 and bus_addr_o=0 after the edge; a late ack is ignored; inst_o=0.
- Ack delayed 5 cycles -> stallreq_o=1 for exactly 5 cycles, bus_addr_o stable throughout, despite cpu_addr_i changing to 0x44.
- IF_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_err_o single pulse on 5th BUSY cycle, bus_req_o=0 next edge, stallreq_o=0 in that cycle.
